// File: rtl/axi_arb_pkg.sv
// Shared types for the two-master AXI write arbiter: channel payloads, FSM states, sizes.
package axi_arb_pkg;

    localparam int unsigned NUM_M  = 2;
    localparam int unsigned ID_W   = 4;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned LEN_W  = 4;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        logic [2:0]        size;
        logic [1:0]        burst;
    } aw_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
        logic              last;
    } w_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [1:0]      resp;
    } b_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2,
        ST_B    = 2'd3
    } state_e;

    // Beat counter increment that sticks at all-ones.
    function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
        return (v == '1) ? v : v + LEN_W'(1);
    endfunction

endpackage

// File: rtl/axi_rr_pick.sv
// Two-way round-robin pick: with both requesting, the master that did not win last time gets it.
module axi_rr_pick
    import axi_arb_pkg::*;
(
    input  logic [NUM_M-1:0] req,
    input  logic             last_grant,
    output logic             grant_c,
    output logic             any_c
);

    always_comb begin
        grant_c = 1'b0;
        any_c   = |req;
        if (&req) begin
            grant_c = ~last_grant;
        end else if (req[1]) begin
            grant_c = 1'b1;
        end
    end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Two-master AXI write arbiter: one outstanding write at a time, AW -> W -> B sequenced by an FSM.
module axi_wr_arbiter
    import axi_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,

    input  aw_t              m_aw [NUM_M],
    input  logic [NUM_M-1:0] m_awvalid,
    output logic [NUM_M-1:0] m_awready,
    input  w_t               m_w [NUM_M],
    input  logic [NUM_M-1:0] m_wvalid,
    output logic [NUM_M-1:0] m_wready,
    output b_t               m_b,
    output logic [NUM_M-1:0] m_bvalid,
    input  logic [NUM_M-1:0] m_bready,

    output aw_t              s_aw,
    output logic             s_awvalid,
    input  logic             s_awready,
    output w_t               s_w,
    output logic             s_wvalid,
    input  logic             s_wready,
    input  b_t               s_b,
    input  logic             s_bvalid,
    output logic             s_bready,

    output logic             owner,
    output logic             busy,
    output logic             err_len
);

    state_e           state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_grant_q, last_grant_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;

    logic             pick_grant_c;
    logic             pick_any_c;

    axi_rr_pick u_pick (
        .req        (m_awvalid),
        .last_grant (last_grant_q),
        .grant_c    (pick_grant_c),
        .any_c      (pick_any_c)
    );

    // Reset returns straight to IDLE; master 0 wins the first contested grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            len_q        <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any_c) begin
                    owner_d = pick_grant_c;
                    state_d = ST_AW;
                end
            end
            ST_AW: begin
                if (m_awvalid[owner_q] && s_awready) begin
                    len_d   = m_aw[owner_q].len;
                    cnt_d   = '0;
                    state_d = ST_W;
                end
            end
            ST_W: begin
                if (m_wvalid[owner_q] && s_wready) begin
                    cnt_d = sat_inc(cnt_q);
                    if (m_w[owner_q].last) begin
                        state_d = ST_B;
                    end
                end
            end
            ST_B: begin
                if (s_bvalid && m_bready[owner_q]) begin
                    last_grant_d = owner_q;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Only the channel matching the current state is connected, and only for the owner.
    always_comb begin
        m_awready = '0;
        m_wready  = '0;
        m_bvalid  = '0;
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b0;
        err_len   = 1'b0;
        s_aw      = m_aw[owner_q];
        s_w       = m_w[owner_q];
        m_b       = s_b;
        case (state_q)
            ST_AW: begin
                s_awvalid          = m_awvalid[owner_q];
                m_awready[owner_q] = s_awready;
            end
            ST_W: begin
                s_wvalid          = m_wvalid[owner_q];
                m_wready[owner_q] = s_wready;
                if (m_wvalid[owner_q] && s_wready) begin
                    err_len = m_w[owner_q].last ? (cnt_q != len_q) : (cnt_q == len_q);
                end
            end
            ST_B: begin
                m_bvalid[owner_q] = s_bvalid;
                s_bready          = m_bready[owner_q];
            end
            default: ;
        endcase
    end

    assign owner = owner_q;
    assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed bench for axi_wr_arbiter: arbitration, burst forwarding, length errors, stalls, reset.
module tb_axi_wr_arbiter;
    import axi_arb_pkg::*;

    logic             clk;
    logic             rst_n;
    aw_t              m_aw [NUM_M];
    logic [NUM_M-1:0] m_awvalid, m_awready;
    w_t               m_w [NUM_M];
    logic [NUM_M-1:0] m_wvalid, m_wready;
    b_t               m_b;
    logic [NUM_M-1:0] m_bvalid, m_bready;
    aw_t              s_aw;
    logic             s_awvalid, s_awready;
    w_t               s_w;
    logic             s_wvalid, s_wready;
    b_t               s_b;
    logic             s_bvalid, s_bready;
    logic             owner, busy, err_len;

    int total = 0;
    int bad   = 0;

    axi_wr_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m_aw      (m_aw),
        .m_awvalid (m_awvalid),
        .m_awready (m_awready),
        .m_w       (m_w),
        .m_wvalid  (m_wvalid),
        .m_wready  (m_wready),
        .m_b       (m_b),
        .m_bvalid  (m_bvalid),
        .m_bready  (m_bready),
        .s_aw      (s_aw),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_w       (s_w),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_b       (s_b),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .owner     (owner),
        .busy      (busy),
        .err_len   (err_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic aw_t mk_aw(input logic m, input logic [3:0] len);
        aw_t a;
        a.id    = 4'(m) + 4'd2;
        a.addr  = m ? 32'h0000_2000 : 32'h0000_1000;
        a.len   = len;
        a.size  = 3'd2;
        a.burst = 2'd1;
        return a;
    endfunction

    function automatic w_t mk_w(input logic m, input int beat, input int nbeats);
        w_t w;
        w.id   = 4'(m) + 4'd2;
        w.data = 32'hD000_0000 | (m ? 32'h100 : 32'h0) | 32'(beat);
        w.strb = 4'hF;
        w.last = (beat == nbeats - 1);
        return w;
    endfunction

    // One full write from master m; checks ordering, stalls and err_len beat by beat.
    task automatic burst(input logic m, input logic [3:0] len, input int nbeats, input int wpre,
                         output int busy_n, output int err_n);
        int  beat    = 0;
        int  cyc     = 0;
        int  cnt;
        bit  aw_done = 0;
        bit  done    = 0;
        logic exp_err;
        w_t   exp_w;
        busy_n = 0;
        err_n  = 0;
        m_aw[m] = mk_aw(m, len);
        for (int i = 0; i < wpre; i++) begin
            m_w[m]      = mk_w(m, 0, nbeats);
            m_wvalid[m] = 1'b1;
            #1;
            chk("w_stall_pre", 64'(m_wready), 64'h0);
            step();
        end
        m_awvalid[m] = 1'b1;
        m_wvalid[m]  = 1'b1;
        while (!done && cyc < 40) begin
            m_w[m] = mk_w(m, beat, nbeats);
            #1;
            if (busy) busy_n++;
            if (err_len) err_n++;
            if (!aw_done) chk("w_stall", 64'(m_wready), 64'h0);
            if (m_awvalid[m] && m_awready[m]) begin
                chk("aw_owner", 64'(owner), 64'(m));
                chk("aw_addr", 64'(s_aw.addr), 64'(mk_aw(m, len).addr));
                aw_done = 1;
            end
            if (s_wvalid && s_wready) begin
                exp_w   = mk_w(m, beat, nbeats);
                cnt     = (beat > 15) ? 15 : beat;
                exp_err = exp_w.last ? (cnt != int'(len)) : (cnt == int'(len));
                chk("w_data", 64'(s_w.data), 64'(exp_w.data));
                chk("w_err_len", 64'(err_len), 64'(exp_err));
                beat++;
            end
            if (m_bvalid[m] && m_bready[m]) done = 1;
            cyc++;
            step();
            if (aw_done) m_awvalid[m] = 1'b0;
            if (beat >= nbeats) m_wvalid[m] = 1'b0;
        end
        chk("burst_done", 64'(done), 64'h1);
        chk("burst_beats", 64'(beat), 64'(nbeats));
    endtask

    int bn, en;

    initial begin
        rst_n     = 1'b0;
        m_aw[0]   = '0;
        m_aw[1]   = '0;
        m_w[0]    = '0;
        m_w[1]    = '0;
        m_awvalid = '0;
        m_wvalid  = '0;
        m_bready  = 2'b11;
        s_awready = 1'b1;
        s_wready  = 1'b1;
        s_b       = '{id: 4'h5, resp: 2'b00};
        s_bvalid  = 1'b1;

        // Reset state
        #12;
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_owner", 64'(owner), 64'h0);
        chk("rst_err", 64'(err_len), 64'h0);
        chk("rst_valids", 64'({s_awvalid, s_wvalid, s_bready, m_awready, m_wready, m_bvalid}), 64'h0);
        rst_n = 1'b1;
        step();

        // Both request: M0 first, then M1
        m_aw[0]   = mk_aw(1'b0, 4'd0);
        m_aw[1]   = mk_aw(1'b1, 4'd0);
        m_w[0]    = mk_w(1'b0, 0, 1);
        m_w[1]    = mk_w(1'b1, 0, 1);
        m_awvalid = 2'b11;
        m_wvalid  = 2'b11;
        #1;
        chk("idle_busy", 64'(busy), 64'h0);
        chk("idle_fwd", 64'({s_awvalid, s_wvalid, m_awready, m_wready}), 64'h0);
        step();
        chk("rr0_owner", 64'(owner), 64'h0);
        chk("rr0_awready", 64'(m_awready), 64'h1);
        chk("rr0_awvalid", 64'(s_awvalid), 64'h1);
        chk("rr0_addr", 64'(s_aw.addr), 64'h1000);
        chk("rr0_wstall", 64'(m_wready), 64'h0);
        step();
        chk("rr0_wready", 64'(m_wready), 64'h1);
        chk("rr0_wdata", 64'(s_w.data), 64'hD000_0000);
        chk("rr0_aw_off", 64'(m_awready), 64'h0);
        step();
        chk("rr0_bvalid", 64'(m_bvalid), 64'h1);
        chk("rr0_bready", 64'(s_bready), 64'h1);
        chk("rr0_bid", 64'(m_b.id), 64'h5);
        step();
        chk("rr_idle_busy", 64'(busy), 64'h0);
        step();
        chk("rr1_owner", 64'(owner), 64'h1);
        chk("rr1_awready", 64'(m_awready), 64'h2);
        step();
        m_awvalid = 2'b00;
        #1;
        chk("rr1_wready", 64'(m_wready), 64'h2);
        chk("rr1_wdata", 64'(s_w.data), 64'hD000_0100);
        step();
        m_wvalid = 2'b00;
        #1;
        chk("rr1_bvalid", 64'(m_bvalid), 64'h2);
        step();
        chk("rr1_done", 64'(busy), 64'h0);

        // M1 alone, len=3, four beats: 7-cycle occupancy = 1 arbitration cycle + 6 busy
        burst(1'b1, 4'd3, 4, 0, bn, en);
        chk("len3_busy", 64'(bn), 64'd6);
        chk("len3_errs", 64'(en), 64'd0);

        // Early last on beat 2 of a len=3 burst
        burst(1'b0, 4'd3, 2, 0, bn, en);
        chk("early_errs", 64'(en), 64'd1);
        chk("early_busy", 64'(bn), 64'd4);

        // W presented three cycles ahead of AW
        burst(1'b0, 4'd1, 2, 3, bn, en);
        chk("wpre_errs", 64'(en), 64'd0);

        // Reset during beat 2 of a len=7 burst
        m_aw[1]   = mk_aw(1'b1, 4'd7);
        m_w[1]    = mk_w(1'b1, 0, 8);
        m_awvalid = 2'b10;
        m_wvalid  = 2'b10;
        #1;
        step();
        chk("mid_aw", 64'(s_awvalid), 64'h1);
        step();
        m_awvalid = 2'b00;
        #1;
        chk("mid_beat1", 64'(s_wvalid), 64'h1);
        step();
        m_w[1] = mk_w(1'b1, 1, 8);
        #1;
        chk("mid_beat2", 64'(s_wvalid), 64'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'h0);
        chk("mid_rst_valids", 64'({s_awvalid, s_wvalid, s_bready, m_awready, m_wready, m_bvalid}), 64'h0);
        chk("mid_rst_err", 64'(err_len), 64'h0);
        m_wvalid  = 2'b00;
        m_awvalid = 2'b11;
        #1;
        rst_n = 1'b1;
        step();
        chk("post_rst_owner", 64'(owner), 64'h0);
        chk("post_rst_awready", 64'(m_awready), 64'h1);
        rst_n     = 1'b0;
        m_awvalid = 2'b00;
        #1;
        rst_n = 1'b1;

        // B held by M1 not ready; M0 request must wait
        m_aw[1]   = mk_aw(1'b1, 4'd0);
        m_w[1]    = mk_w(1'b1, 0, 1);
        m_awvalid = 2'b10;
        m_wvalid  = 2'b10;
        m_bready  = 2'b01;
        step();
        step();
        m_awvalid = 2'b00;
        step();
        m_wvalid  = 2'b00;
        m_awvalid = 2'b01;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bhold_bvalid", 64'(m_bvalid), 64'h2);
            chk("bhold_sready", 64'(s_bready), 64'h0);
            chk("bhold_owner", 64'(owner), 64'h1);
            chk("bhold_awready", 64'(m_awready), 64'h0);
            step();
        end
        m_bready = 2'b11;
        #1;
        chk("bhold_release", 64'(s_bready), 64'h1);
        step();
        chk("bhold_idle", 64'(busy), 64'h0);
        step();
        chk("bhold_next_owner", 64'(owner), 64'h0);
        chk("bhold_next_aw", 64'(m_awready), 64'h1);

        // awvalid dropped while in AW: stay in AW with the same owner
        m_awvalid = 2'b00;
        step();
        chk("awdrop_busy", 64'(busy), 64'h1);
        chk("awdrop_owner", 64'(owner), 64'h0);
        chk("awdrop_valid", 64'(s_awvalid), 64'h0);
        chk("awdrop_wready", 64'(m_wready), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
